backtrack_unit: RTL and testbench

Conflict-recovery controller for the DPLL solver core, and initiator/consumer for the trace table. On a conflict it pops trace entries newest-first and unassigns every forced (F) variable. At the first decision (D) entry it reassigns that variable to the opposite value and pushes it back as forced. If the stack runs out with no decision found, the formula is UNSAT.

---
 rtl/sat_pkg.sv | 30 +++
 rtl/backtrack_unit.sv | 118 +++++++++++
 tb/tb_backtrack_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sat_pkg.sv
// Shared types for the DPLL solver core: problem sizing, trace-table entry format
// and the backtrack controller state encoding.
package sat_pkg;

    localparam int NUM_VARIABLE = 128;
    localparam int VAR_W        = 9;

    typedef enum logic {
        TT_DECISION = 1'b0,
        TT_FORCED   = 1'b1
    } trace_type_e;

    // Field is var_id because "var" is a reserved word.
    typedef struct packed {
        trace_type_e      t;
        logic             val;
        logic [VAR_W-1:0] var_id;
    } trace_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP_REQ,
        ST_POP_WAIT,
        ST_UNASSIGN,
        ST_ASSIGN,
        ST_PUSH,
        ST_FINISH
    } bt_state_e;

endpackage

// File: rtl/backtrack_unit.sv
// Conflict recovery: pops trace entries newest-first, unassigns forced vars, flips and re-pushes the first decision.
// Latency: tt_pop one cycle after conflict_start; 3 cycles per forced entry, 5 for the decision (through bt_done).
// Backpressure: unassign/assign valids hold with stable data until ready; POP_WAIT stalls indefinitely for the response.
module backtrack_unit
    import sat_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             conflict_start,
    output logic             busy,
    output logic             tt_pop,
    input  logic             tt_rsp_valid,
    input  logic             tt_rsp_empty,
    input  logic             tt_rsp_type,
    input  logic             tt_rsp_val,
    input  logic [VAR_W-1:0] tt_rsp_var,
    output logic             tt_push,
    output logic             tt_push_type,
    output logic             tt_push_val,
    output logic [VAR_W-1:0] tt_push_var,
    output logic             unassign_valid,
    output logic [VAR_W-1:0] unassign_var,
    input  logic             unassign_ready,
    output logic             assign_valid,
    output logic [VAR_W-1:0] assign_var,
    output logic             assign_val,
    input  logic             assign_ready,
    output logic             bt_done,
    output logic             unsat,
    output logic [VAR_W:0]   pop_count
);

    localparam logic [VAR_W:0] POP_MAX = (VAR_W+1)'(NUM_VARIABLE);

    bt_state_e    state;
    bt_state_e    state_nxt;
    trace_entry_t entry;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Outputs decode from state only; data fields are zero outside their own state.
    always_comb begin
        state_nxt      = state;
        busy           = (state != ST_IDLE);
        tt_pop         = 1'b0;
        tt_push        = 1'b0;
        tt_push_type   = 1'b0;
        tt_push_val    = 1'b0;
        tt_push_var    = '0;
        unassign_valid = 1'b0;
        unassign_var   = '0;
        assign_valid   = 1'b0;
        assign_var     = '0;
        assign_val     = 1'b0;
        bt_done        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (conflict_start && !unsat) state_nxt = ST_POP_REQ;
            end
            ST_POP_REQ: begin
                tt_pop    = 1'b1;
                state_nxt = ST_POP_WAIT;
            end
            ST_POP_WAIT: begin
                if (tt_rsp_valid) begin
                    if (tt_rsp_empty)                  state_nxt = ST_FINISH;
                    else if (tt_rsp_type == TT_FORCED) state_nxt = ST_UNASSIGN;
                    else                               state_nxt = ST_ASSIGN;
                end
            end
            ST_UNASSIGN: begin
                unassign_valid = 1'b1;
                unassign_var   = entry.var_id;
                if (unassign_ready) state_nxt = ST_POP_REQ;
            end
            ST_ASSIGN: begin
                assign_valid = 1'b1;
                assign_var   = entry.var_id;
                assign_val   = ~entry.val;
                if (assign_ready) state_nxt = ST_PUSH;
            end
            ST_PUSH: begin
                tt_push      = 1'b1;
                tt_push_type = TT_FORCED;
                tt_push_val  = ~entry.val;
                tt_push_var  = entry.var_id;
                state_nxt    = ST_FINISH;
            end
            ST_FINISH: begin
                bt_done   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pop_count <= '0;
            entry     <= '0;
            unsat     <= 1'b0;
        end else begin
            if (state == ST_IDLE && conflict_start && !unsat) pop_count <= '0;
            if (state == ST_POP_WAIT && tt_rsp_valid) begin
                if (tt_rsp_empty) begin
                    unsat <= 1'b1;
                end else begin
                    entry <= '{t: trace_type_e'(tt_rsp_type), val: tt_rsp_val, var_id: tt_rsp_var};
                    if (pop_count < POP_MAX) pop_count <= pop_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_backtrack_unit.sv
// Directed bench for backtrack_unit: a queue-backed trace table responder and
// an assignment-table model with programmable response and ready delays.
module tb_backtrack_unit;
    import sat_pkg::*;

    logic             clk = 1'b0;
    logic             reset, conflict_start, busy, tt_pop;
    logic             tt_rsp_valid, tt_rsp_empty, tt_rsp_type, tt_rsp_val;
    logic [VAR_W-1:0] tt_rsp_var;
    logic             tt_push, tt_push_type, tt_push_val;
    logic [VAR_W-1:0] tt_push_var;
    logic             unassign_valid, unassign_ready;
    logic [VAR_W-1:0] unassign_var;
    logic             assign_valid, assign_val, assign_ready;
    logic [VAR_W-1:0] assign_var;
    logic             bt_done, unsat;
    logic [VAR_W:0]   pop_count;
    logic [46:0]      all_out;

    always #5 clk = ~clk;

    backtrack_unit dut (
        .clk(clk), .reset(reset), .conflict_start(conflict_start), .busy(busy),
        .tt_pop(tt_pop), .tt_rsp_valid(tt_rsp_valid), .tt_rsp_empty(tt_rsp_empty),
        .tt_rsp_type(tt_rsp_type), .tt_rsp_val(tt_rsp_val), .tt_rsp_var(tt_rsp_var),
        .tt_push(tt_push), .tt_push_type(tt_push_type), .tt_push_val(tt_push_val),
        .tt_push_var(tt_push_var), .unassign_valid(unassign_valid),
        .unassign_var(unassign_var), .unassign_ready(unassign_ready),
        .assign_valid(assign_valid), .assign_var(assign_var), .assign_val(assign_val),
        .assign_ready(assign_ready), .bt_done(bt_done), .unsat(unsat), .pop_count(pop_count)
    );

    assign all_out = {busy, tt_pop, tt_push, tt_push_type, tt_push_val, tt_push_var,
                      unassign_valid, unassign_var, assign_valid, assign_var, assign_val,
                      bt_done, unsat, pop_count};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int c0 = 0;

    trace_entry_t        stack[$];
    logic [VAR_W-1:0]    ua_log[$];
    logic [VAR_W:0]      as_log[$];
    trace_entry_t        push_log[$];
    int                  pop_cnt, done_cnt, done_cyc, first_pop_cyc, stable_err;
    logic                unsat_at_done;
    int                  rsp_delay = 0;
    int                  ready_delay = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Trace-table and assignment-table models; drive at negedge, log handshakes.
    initial begin : responder
        bit               pend;
        int               wctr, ua_wait, as_wait;
        logic             prev_ua_vld, prev_as_vld;
        logic [VAR_W-1:0] prev_ua_var;
        logic [VAR_W:0]   prev_as_dat;
        trace_entry_t     e;
        pend = 0; wctr = 0; ua_wait = 0; as_wait = 0;
        prev_ua_vld = 0; prev_as_vld = 0; prev_ua_var = '0; prev_as_dat = '0;
        tt_rsp_valid = 0; tt_rsp_empty = 0; tt_rsp_type = 0; tt_rsp_val = 0; tt_rsp_var = '0;
        unassign_ready = 0; assign_ready = 0;
        forever begin
            @(negedge clk);
            tt_rsp_valid = 0; tt_rsp_empty = 0;
            if (reset) begin
                pend = 0; ua_wait = 0; as_wait = 0; prev_ua_vld = 0; prev_as_vld = 0;
                unassign_ready = 0; assign_ready = 0;
            end else begin
                if (pend) begin
                    if (wctr == 0) begin
                        pend = 0;
                        tt_rsp_valid = 1;
                        if (stack.size() == 0) begin
                            tt_rsp_empty = 1; tt_rsp_type = 0; tt_rsp_val = 0; tt_rsp_var = '0;
                        end else begin
                            e = stack.pop_back();
                            tt_rsp_type = e.t; tt_rsp_val = e.val; tt_rsp_var = e.var_id;
                        end
                    end else wctr--;
                end
                if (tt_pop) begin
                    pop_cnt++;
                    if (first_pop_cyc < 0) first_pop_cyc = cyc;
                    pend = 1; wctr = rsp_delay;
                end
                if (prev_ua_vld && (!unassign_valid || unassign_var !== prev_ua_var)) stable_err++;
                if (prev_as_vld && (!assign_valid || {assign_var, assign_val} !== prev_as_dat)) stable_err++;
                if (unassign_valid) begin
                    if (ua_wait < ready_delay) begin unassign_ready = 0; ua_wait++; end
                    else unassign_ready = 1;
                end else unassign_ready = (ready_delay == 0);
                if (assign_valid) begin
                    if (as_wait < ready_delay) begin assign_ready = 0; as_wait++; end
                    else assign_ready = 1;
                end else assign_ready = (ready_delay == 0);
                if (unassign_valid && unassign_ready) begin
                    ua_log.push_back(unassign_var); ua_wait = 0; prev_ua_vld = 0;
                end else begin
                    prev_ua_vld = unassign_valid; prev_ua_var = unassign_var;
                end
                if (assign_valid && assign_ready) begin
                    as_log.push_back({assign_var, assign_val}); as_wait = 0; prev_as_vld = 0;
                end else begin
                    prev_as_vld = assign_valid; prev_as_dat = {assign_var, assign_val};
                end
                if (tt_push) begin
                    e = '{t: trace_type_e'(tt_push_type), val: tt_push_val, var_id: tt_push_var};
                    push_log.push_back(e);
                    stack.push_back(e);
                end
                if (bt_done) begin
                    done_cnt++; done_cyc = cyc; unsat_at_done = unsat;
                end
            end
        end
    end

    task automatic push_entry(input logic t, input logic v, input logic [VAR_W-1:0] x);
        trace_entry_t e;
        e = '{t: trace_type_e'(t), val: v, var_id: x};
        stack.push_back(e);
    endtask

    task automatic load_fig1();
        stack.delete();
        push_entry(1'b0, 1'b1, 9'd5);
        push_entry(1'b1, 1'b0, 9'd7);
        push_entry(1'b1, 1'b1, 9'd9);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
    endtask

    task automatic start_bt();
        @(posedge clk); #1;
        pop_cnt = 0; done_cnt = 0; done_cyc = -1; first_pop_cyc = -1; stable_err = 0;
        unsat_at_done = 0;
        ua_log.delete(); as_log.delete(); push_log.delete();
        conflict_start = 1; c0 = cyc;
        @(posedge clk); #1 conflict_start = 0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300 && done_cnt == 0; i++) @(posedge clk);
        #1;
        vectors++;
        if (done_cnt == 0) begin
            $display("FAIL %s_timeout: bt_done not seen, done_cnt=%0d need 1", name, done_cnt);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        reset = 1; conflict_start = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (all_out !== '0) begin
            $display("FAIL reset_outputs: got %h need 0", all_out); miscompares++;
        end
        reset = 0;
    endtask

    task automatic test_fig1();
        trace_entry_t exp;
        exp = '{t: TT_FORCED, val: 1'b0, var_id: 9'd5};
        load_fig1(); rsp_delay = 0; ready_delay = 0;
        start_bt(); wait_done("fig1");
        vectors++;
        if (ua_log.size() != 2 || ua_log[0] !== 9'd9 || ua_log[1] !== 9'd7) begin
            $display("FAIL fig1_unassign: got n=%0d [%0d,%0d] need [9,7]", ua_log.size(), ua_log[0], ua_log[1]); miscompares++;
        end
        vectors++;
        if (as_log.size() != 1 || as_log[0] !== {9'd5, 1'b0}) begin
            $display("FAIL fig1_assign: got n=%0d %h need %h", as_log.size(), as_log[0], {9'd5, 1'b0}); miscompares++;
        end
        vectors++;
        if (push_log.size() != 1 || push_log[0] !== exp) begin
            $display("FAIL fig1_push: got n=%0d %h need %h", push_log.size(), push_log[0], exp); miscompares++;
        end
        vectors++;
        if (pop_count !== 10'd3 || unsat !== 1'b0) begin
            $display("FAIL fig1_count: got pop_count=%0d unsat=%b need 3 0", pop_count, unsat); miscompares++;
        end
        // Two F entries at 3 cycles each plus the 5-cycle D sequence.
        vectors++;
        if (done_cyc != c0 + 11 || pop_cnt != 3) begin
            $display("FAIL fig1_timing: got done=+%0d pops=%0d need +11 3", done_cyc - c0, pop_cnt); miscompares++;
        end
    endtask

    task automatic test_empty_stack();
        stack.delete();
        start_bt(); wait_done("empty");
        vectors++;
        if (unsat !== 1'b1 || unsat_at_done !== 1'b1 || pop_count !== 10'd0 || pop_cnt != 1) begin
            $display("FAIL empty_unsat: got unsat=%b at_done=%b pop_count=%0d pops=%0d need 1 1 0 1",
                     unsat, unsat_at_done, pop_count, pop_cnt); miscompares++;
        end
        start_bt();
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (pop_cnt != 0 || busy !== 1'b0 || unsat !== 1'b1) begin
            $display("FAIL empty_sticky: got pops=%0d busy=%b unsat=%b need 0 0 1", pop_cnt, busy, unsat); miscompares++;
        end
        do_reset();
        vectors++;
        if (unsat !== 1'b0) begin
            $display("FAIL empty_clear: got unsat=%b need 0", unsat); miscompares++;
        end
    endtask

    task automatic test_top_decision();
        trace_entry_t exp;
        exp = '{t: TT_FORCED, val: 1'b1, var_id: 9'd3};
        stack.delete(); push_entry(1'b0, 1'b0, 9'd3);
        start_bt(); wait_done("topd");
        vectors++;
        if (ua_log.size() != 0 || as_log.size() != 1 || as_log[0] !== {9'd3, 1'b1}) begin
            $display("FAIL topd_assign: got ua_n=%0d as_n=%0d as=%h need 0 1 %h",
                     ua_log.size(), as_log.size(), as_log[0], {9'd3, 1'b1}); miscompares++;
        end
        vectors++;
        if (push_log.size() != 1 || push_log[0] !== exp || pop_count !== 10'd1) begin
            $display("FAIL topd_push: got n=%0d %h pop_count=%0d need 1 %h 1",
                     push_log.size(), push_log[0], pop_count, exp); miscompares++;
        end
        // POP_REQ at cycle 1 through FINISH at cycle 5.
        vectors++;
        if (first_pop_cyc != c0 + 1 || done_cyc != c0 + 5) begin
            $display("FAIL topd_timing: got pop=+%0d done=+%0d need +1 +5", first_pop_cyc - c0, done_cyc - c0); miscompares++;
        end
    endtask

    task automatic test_forced_only();
        stack.delete(); push_entry(1'b1, 1'b1, 9'd2); push_entry(1'b1, 1'b0, 9'd4);
        start_bt(); wait_done("fonly");
        vectors++;
        if (ua_log.size() != 2 || ua_log[0] !== 9'd4 || ua_log[1] !== 9'd2) begin
            $display("FAIL fonly_unassign: got n=%0d [%0d,%0d] need [4,2]", ua_log.size(), ua_log[0], ua_log[1]); miscompares++;
        end
        vectors++;
        if (unsat !== 1'b1 || pop_count !== 10'd2 || pop_cnt != 3 || as_log.size() != 0 || push_log.size() != 0) begin
            $display("FAIL fonly_unsat: got unsat=%b pop_count=%0d pops=%0d as=%0d push=%0d need 1 2 3 0 0",
                     unsat, pop_count, pop_cnt, as_log.size(), push_log.size()); miscompares++;
        end
        do_reset();
    endtask

    task automatic test_stall();
        trace_entry_t exp;
        exp = '{t: TT_FORCED, val: 1'b0, var_id: 9'd5};
        load_fig1(); rsp_delay = 3; ready_delay = 4;
        start_bt(); wait_done("stall");
        vectors++;
        if (stable_err != 0 || pop_cnt != 3) begin
            $display("FAIL stall_stable: got stable_err=%0d pops=%0d need 0 3", stable_err, pop_cnt); miscompares++;
        end
        vectors++;
        if (ua_log.size() != 2 || ua_log[0] !== 9'd9 || ua_log[1] !== 9'd7 ||
            as_log.size() != 1 || as_log[0] !== {9'd5, 1'b0}) begin
            $display("FAIL stall_seq: got ua_n=%0d as_n=%0d as=%h need 2 1 %h",
                     ua_log.size(), as_log.size(), as_log[0], {9'd5, 1'b0}); miscompares++;
        end
        vectors++;
        if (push_log.size() != 1 || push_log[0] !== exp || pop_count !== 10'd3 || unsat !== 1'b0) begin
            $display("FAIL stall_result: got push=%h pop_count=%0d unsat=%b need %h 3 0",
                     push_log[0], pop_count, unsat, exp); miscompares++;
        end
        rsp_delay = 0; ready_delay = 0;
    endtask

    task automatic test_busy_and_reset();
        bit seen;
        load_fig1();
        start_bt();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            $display("FAIL busy_flag: got busy=%b need 1", busy); miscompares++;
        end
        conflict_start = 1;
        @(posedge clk); #1 conflict_start = 0;
        wait_done("busy");
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (done_cnt != 1 || pop_cnt != 3 || pop_count !== 10'd3) begin
            $display("FAIL busy_ignored: got done=%0d pops=%0d pop_count=%0d need 1 3 3",
                     done_cnt, pop_cnt, pop_count); miscompares++;
        end
        load_fig1(); ready_delay = 50;
        start_bt();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (unassign_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        vectors++;
        if (!seen) begin
            $display("FAIL midreset_reach: got unassign_valid=%b need 1", unassign_valid); miscompares++;
        end
        reset = 1;
        @(posedge clk); #1;
        vectors++;
        if (all_out !== '0 || ua_log.size() != 0) begin
            $display("FAIL midreset_outputs: got %h ua_n=%0d need 0 0", all_out, ua_log.size()); miscompares++;
        end
        reset = 0; ready_delay = 0;
        start_bt(); wait_done("after_reset");
        vectors++;
        if (ua_log.size() != 1 || ua_log[0] !== 9'd7 || as_log.size() != 1 ||
            as_log[0] !== {9'd5, 1'b0} || pop_count !== 10'd2 || unsat !== 1'b0) begin
            $display("FAIL after_reset: got ua_n=%0d ua0=%0d as=%h pop_count=%0d unsat=%b need 1 7 %h 2 0",
                     ua_log.size(), ua_log[0], as_log[0], pop_count, unsat, {9'd5, 1'b0}); miscompares++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, need completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fig1();
        test_empty_stack();
        test_top_decision();
        test_forced_only();
        test_stall();
        test_busy_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
